// File: rtl/dcache_nway.sv
// dcache_nway: N-way set-associative write-back data cache.
// A miss holds the CPU in stall while the victim line is written back if it
// is dirty, and then the line is refilled one word per beat. When the FSM
// returns to IDLE the held request hits and completes.
module dcache_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        datareq,
  input  logic        wren,
  input  logic [3:0]  byteen,
  input  logic [31:0] dataaddr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        hit,
  output logic        stall,
  output logic        mem_write_req,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  input  logic        mem_write_val,
  output logic        mem_read_req,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_read_data,
  input  logic        mem_read_val
);

  localparam int WB  = $clog2(LINE_WORDS);
  localparam int OFF = WB + 2;
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 32 - OFF - IDX;
  // The way index is kept at least 1 bit wide; with one way it stays 0.
  localparam int VW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WRBACK, REFILL} state_t;

  // Line state and data storage
  logic [WAYS-1:0][SETS-1:0]          valid_q, valid_d;
  logic [WAYS-1:0][SETS-1:0]          dirty_q, dirty_d;
  logic [WAYS-1:0][SETS-1:0][TAG-1:0] tag_q, tag_d;
  logic [SETS-1:0][VW-1:0]            vptr_q, vptr_d;
  logic [31:0]                        data_q [WAYS][SETS][LINE_WORDS];

  // Miss-handling registers
  state_t          state_q, state_d;
  logic [WB-1:0]   wcnt_q, wcnt_d;
  logic [WB-1:0]   rcnt_q, rcnt_d;
  logic [TAG-1:0]  vtag_q, vtag_d;
  logic [IDX-1:0]  vidx_q, vidx_d;
  logic [VW-1:0]   vway_q, vway_d;
  logic [31:0]     laddr_q, laddr_d;
  logic [31:0]     readdata_q, readdata_d;

  // Single data-array write port shared by store hits and refill beats
  logic            data_we;
  logic [VW-1:0]   data_way;
  logic [IDX-1:0]  data_set;
  logic [WB-1:0]   data_word;
  logic [31:0]     data_wval;
  logic [3:0]      data_ben;

  // Request address fields; the byte offset bits are not used.
  logic [TAG-1:0]  req_tag;
  logic [IDX-1:0]  req_idx;
  logic [WB-1:0]   req_word;
  logic            unused_addr_bits;

  assign req_tag          = dataaddr[31 -: TAG];
  assign req_idx          = dataaddr[OFF +: IDX];
  assign req_word         = dataaddr[2 +: WB];
  assign unused_addr_bits = ^dataaddr[1:0];

  logic [WAYS-1:0] way_match;
  logic [VW-1:0]   hit_way;
  logic [VW-1:0]   vsel;

  // Per-way tag compare in the indexed set
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
    assign way_match[gi] = valid_q[gi][req_idx] && (tag_q[gi][req_idx] == req_tag);
  end

  assign hit = datareq && (|way_match);

  // Encode the (at most one) matching way
  always_comb begin
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (way_match[i]) hit_way = VW'(i);
    end
  end

  // Victim: lowest-numbered invalid way, else the set's round-robin pointer
  always_comb begin
    vsel = vptr_q[req_idx];
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[i][req_idx]) vsel = VW'(i);
    end
  end

  // Next-state logic for the FSM, line state and data write port
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    vtag_d     = vtag_q;
    vidx_d     = vidx_q;
    vway_d     = vway_q;
    laddr_d    = laddr_q;
    readdata_d = '0;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    vptr_d     = vptr_q;
    data_we    = 1'b0;
    data_way   = hit_way;
    data_set   = req_idx;
    data_word  = req_word;
    data_wval  = writedata;
    data_ben   = byteen;
    case (state_q)
      IDLE: begin
        if (datareq) begin
          if (hit) begin
            if (wren) begin
              data_we                   = 1'b1;
              dirty_d[hit_way][req_idx] = 1'b1;
            end else begin
              readdata_d = data_q[hit_way][req_idx][req_word];
            end
          end else begin
            vtag_d  = tag_q[vsel][req_idx];
            vidx_d  = req_idx;
            vway_d  = vsel;
            laddr_d = dataaddr;
            state_d = (valid_q[vsel][req_idx] && dirty_q[vsel][req_idx]) ? WRBACK : REFILL;
          end
        end
      end
      WRBACK: begin
        if (mem_write_val) begin
          if (wcnt_q == WB'(LINE_WORDS - 1)) begin
            wcnt_d  = '0;
            state_d = REFILL;
          end else begin
            wcnt_d = wcnt_q + WB'(1);
          end
        end
      end
      REFILL: begin
        if (mem_read_val) begin
          data_we   = 1'b1;
          data_way  = vway_q;
          data_set  = vidx_q;
          data_word = rcnt_q;
          data_wval = mem_read_data;
          data_ben  = 4'hF;
          if (rcnt_q == WB'(LINE_WORDS - 1)) begin
            rcnt_d                 = '0;
            valid_d[vway_q][vidx_q] = 1'b1;
            dirty_d[vway_q][vidx_q] = 1'b0;
            tag_d[vway_q][vidx_q]   = laddr_q[31 -: TAG];
            if (WAYS > 1) vptr_d[vidx_q] = vptr_q[vidx_q] + VW'(1);
            state_d                = IDLE;
          end else begin
            rcnt_d = rcnt_q + WB'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and line-state registers; reset drops any burst in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      vtag_q     <= '0;
      vidx_q     <= '0;
      vway_q     <= '0;
      laddr_q    <= '0;
      readdata_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      tag_q      <= '0;
      vptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      vtag_q     <= vtag_d;
      vidx_q     <= vidx_d;
      vway_q     <= vway_d;
      laddr_q    <= laddr_d;
      readdata_q <= readdata_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      vptr_q     <= vptr_d;
    end
  end

  // Data array: byte-enabled write, contents need no reset (valid bits guard them)
  always_ff @(posedge clk) begin
    if (data_we) begin
      for (int b = 0; b < 4; b++) begin
        if (data_ben[b]) data_q[data_way][data_set][data_word][8*b +: 8] <= data_wval[8*b +: 8];
      end
    end
  end

  assign readdata       = readdata_q;
  assign mem_write_req  = (state_q == WRBACK);
  assign mem_write_addr = {vtag_q, vidx_q, {OFF{1'b0}}};
  assign mem_write_data = (state_q == WRBACK) ? data_q[vway_q][vidx_q][wcnt_q] : 32'd0;
  assign mem_read_req   = (state_q == REFILL);
  assign mem_read_addr  = {laddr_q[31:OFF], {OFF{1'b0}}};
  assign stall          = !reset && datareq && ((state_q != IDLE) || !hit);

endmodule

// File: tb/tb_dcache_nway.sv
// tb_dcache_nway: directed test of dcache_nway with a beat-level memory
// responder and scoreboard queues for load data and writeback beats.
module tb_dcache_nway;

  logic        clk = 1'b0;
  logic        reset;
  logic        datareq;
  logic        wren;
  logic [3:0]  byteen;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        hit;
  logic        stall;
  logic        mem_write_req;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_val;
  logic        mem_read_req;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_read_data;
  logic        mem_read_val;

  always #5 clk = ~clk;

  dcache_nway dut (
    .clk           (clk),
    .reset         (reset),
    .datareq       (datareq),
    .wren          (wren),
    .byteen        (byteen),
    .dataaddr      (dataaddr),
    .writedata     (writedata),
    .readdata      (readdata),
    .hit           (hit),
    .stall         (stall),
    .mem_write_req (mem_write_req),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_write_val (mem_write_val),
    .mem_read_req  (mem_read_req),
    .mem_read_addr (mem_read_addr),
    .mem_read_data (mem_read_data),
    .mem_read_val  (mem_read_val)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem  [1024];   // backing memory seen by the responder
  logic [31:0] refm [1024];   // architectural view the CPU should observe
  logic [31:0] exp_rd_q [$];
  beat_t       exp_wb_q [$];
  logic [31:0] exp_raddr = 32'h0;
  bit          gap_mode = 1'b0;

  // Responder state
  int          rd_total = 0;
  int          wr_total = 0;
  int          wr_at_rd_start = 0;
  int          rd_beat_cur = 0;
  int          wr_beat_cur = 0;
  int          rgap = 0;
  bit          r_iss = 1'b0;
  bit          w_iss = 1'b0;
  logic [31:0] wa_p, wd_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: on each falling edge, account for the beat offered on
  // the previous falling edge, then offer the next beat.
  initial begin
    beat_t e;
    mem_read_val  = 1'b0;
    mem_write_val = 1'b0;
    mem_read_data = 32'h0;
    forever begin
      @(negedge clk);
      if (r_iss && !reset) begin
        if (rd_beat_cur == 0) wr_at_rd_start = wr_total;
        rd_total++;
        rd_beat_cur++;
      end
      if (!mem_read_req) rd_beat_cur = 0;
      if (w_iss && !reset) begin
        chk("wb_beat_expected", 32'(exp_wb_q.size() != 0), 32'd1);
        if (exp_wb_q.size() != 0) begin
          e = exp_wb_q.pop_front();
          chk("mem_write_addr", wa_p, e.addr);
          chk("mem_write_data", wd_p, e.data);
        end
        mem[((wa_p >> 2) + 32'(wr_beat_cur)) % 1024] = wd_p;
        wr_total++;
        wr_beat_cur++;
      end
      if (!mem_write_req) wr_beat_cur = 0;
      r_iss = 1'b0;
      mem_read_val = 1'b0;
      mem_read_data = $urandom;
      if (mem_read_req && !reset) begin
        if (rgap > 0) begin
          rgap--;
        end else begin
          chk("mem_read_addr", mem_read_addr, exp_raddr);
          mem_read_data = mem[((mem_read_addr >> 2) + 32'(rd_beat_cur)) % 1024];
          mem_read_val  = 1'b1;
          r_iss         = 1'b1;
          rgap          = gap_mode ? int'($urandom_range(0, 3)) : 0;
        end
      end else begin
        rgap = 0;
      end
      w_iss = 1'b0;
      mem_write_val = 1'b0;
      if (mem_write_req && !reset) begin
        wa_p          = mem_write_addr;
        wd_p          = mem_write_data;
        mem_write_val = 1'b1;
        w_iss         = 1'b1;
      end
    end
  end

  // One CPU access held until stall drops, then completed on the next edge.
  task automatic access(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output int stalls, output int beats,
                        output int wreq, output logic hit0);
    int rd0;
    logic [31:0] w;
    rd0 = rd_total;
    @(negedge clk); #2;
    datareq = 1'b1; wren = we; dataaddr = a; byteen = be; writedata = wd;
    if (we) begin
      w = refm[a[11:2]];
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      refm[a[11:2]] = w;
      exp_rd_q.push_back(32'h0);
    end else begin
      exp_rd_q.push_back(refm[a[11:2]]);
    end
    #1;
    hit0 = hit;
    stalls = 0;
    wreq = 0;
    while (stall && stalls < 400) begin
      stalls++;
      if (mem_write_req) wreq++;
      @(negedge clk); #3;
    end
    chk("stall_released", 32'(stall), 32'd0);
    @(negedge clk); #2;
    datareq = 1'b0; wren = 1'b0;
    chk("readdata", readdata, exp_rd_q.pop_front());
    beats = rd_total - rd0;
    $display("access we=%0d addr=%h stalls=%0d read_beats=%0d wr_req_cycles=%0d readdata=%h",
             we, a, stalls, beats, wreq, readdata);
  endtask

  initial begin
    int st, bt, wq, wr0, cyc;
    logic h0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = 32'(i) - 32'd48;
      refm[i] = 32'(i) - 32'd48;
    end
    // Reset, with a request pending to show stall is held low
    reset = 1'b1; datareq = 1'b1; wren = 1'b0; byteen = 4'h0;
    dataaddr = 32'h100; writedata = 32'h0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_read_req", 32'(mem_read_req), 32'd0);
    chk("rst_mem_write_req", 32'(mem_write_req), 32'd0);
    chk("rst_mem_write_data", mem_write_data, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    datareq = 1'b0;
    reset = 1'b0;

    // Cold load of 0x100: 8 refill beats, no writeback, one miss-detect cycle
    exp_raddr = 32'h100;
    access(1'b0, 32'h100, 4'h0, 32'h0, st, bt, wq, h0);
    chk("cold_read_beats", 32'(bt), 32'd8);
    chk("cold_stall_cycles", 32'(st), 32'd9);
    chk("cold_no_write_req", 32'(wq), 32'd0);

    // Partial store hit on 0x104
    access(1'b1, 32'h104, 4'b0101, 32'hAABBCCDD, st, bt, wq, h0);
    chk("store_hit", 32'(h0), 32'd1);
    chk("store_no_stall", 32'(st), 32'd0);
    access(1'b0, 32'h104, 4'h0, 32'h0, st, bt, wq, h0);
    chk("store_merged_literal", readdata, 32'h00BB00DD);

    // Fill the other way of set 0, then force eviction of the dirty 0x100 line
    exp_raddr = 32'h200;
    access(1'b0, 32'h200, 4'h0, 32'h0, st, bt, wq, h0);
    chk("fill200_no_write_req", 32'(wq), 32'd0);
    for (int i = 0; i < 8; i++) exp_wb_q.push_back('{addr: 32'h100, data: refm[64 + i]});
    wr0 = wr_total;
    exp_raddr = 32'h300;
    access(1'b0, 32'h300, 4'h0, 32'h0, st, bt, wq, h0);
    chk("evict_write_beats", 32'(wr_total - wr0), 32'd8);
    chk("evict_wb_before_refill", 32'(wr_at_rd_start - wr0), 32'd8);
    chk("evict_wb_queue_drained", 32'(exp_wb_q.size()), 32'd0);
    chk("evict_read_beats", 32'(bt), 32'd8);
    chk("evict_stall_cycles", 32'(st), 32'd17);
    access(1'b0, 32'h208, 4'h0, 32'h0, st, bt, wq, h0);
    chk("way1_kept_hit", 32'(st), 32'd0);
    exp_raddr = 32'h100;
    access(1'b0, 32'h104, 4'h0, 32'h0, st, bt, wq, h0);
    chk("way0_evicted_miss", 32'(bt), 32'd8);

    // Refill with random gaps between beats, then read every word back
    gap_mode = 1'b1;
    exp_raddr = 32'h420;
    access(1'b0, 32'h424, 4'h0, 32'h0, st, bt, wq, h0);
    chk("gap_read_beats", 32'(bt), 32'd8);
    gap_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      access(1'b0, 32'h420 + 32'(4 * i), 4'h0, 32'h0, st, bt, wq, h0);
      chk("gap_word_hit", 32'(st), 32'd0);
    end

    // Reset while the 4th refill beat is offered
    exp_raddr = 32'h540;
    @(negedge clk); #2;
    datareq = 1'b1; wren = 1'b0; dataaddr = 32'h548;
    cyc = 0;
    while (!(mem_read_val && rd_beat_cur == 3) && cyc < 200) begin
      cyc++;
      @(negedge clk); #2;
    end
    chk("abort_reached_beat4", 32'(rd_beat_cur), 32'd3);
    reset = 1'b1;
    #1;
    chk("abort_mem_read_req", 32'(mem_read_req), 32'd0);
    chk("abort_mem_write_req", 32'(mem_write_req), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_readdata", readdata, 32'd0);
    datareq = 1'b0;
    @(negedge clk); #2;
    reset = 1'b0;
    access(1'b0, 32'h548, 4'h0, 32'h0, st, bt, wq, h0);
    chk("after_abort_miss_again", 32'(bt), 32'd8);
    chk("after_abort_stall_cycles", 32'(st), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_nway.md
DCACHE_NWAY -- requirements
Module: dcache_nway

Interface
REQ-001 Parameter WAYS, default 2, associativity; legal values 1, 2 and 4.
REQ-002 Parameter SETS, default 8, sets per way; power of two, at least 2.
REQ-003 Parameter LINE_WORDS, default 8, 32-bit words per line; power of two, at least 2.
REQ-004 Derived widths: OFF = log2(LINE_WORDS)+2, IDX = log2(SETS), TAG = 32-OFF-IDX; dataaddr = {tag, index, word, 2'b00}.
REQ-005 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1, asynchronous active-high reset.
REQ-007 Port datareq, input, 1, CPU access request.
REQ-008 Port wren, input, 1, 1 = store, 0 = load.
REQ-009 Port byteen, input, 4, store byte enables; bit n covers writedata[8n+7:8n].
REQ-010 Port dataaddr, input, 32, CPU byte address; bits [1:0] are ignored.
REQ-011 Port writedata, input, 32, store data.
REQ-012 Port readdata, output, 32, registered load data.
REQ-013 Port hit, output, 1, combinational tag match in the indexed set.
REQ-014 Port stall, output, 1, CPU SHALL hold its request stable while this is 1.
REQ-015 Ports mem_write_req (o,1), mem_write_addr (o,32), mem_write_data (o,32), mem_write_val (i,1): writeback beat channel.
REQ-016 Ports mem_read_req (o,1), mem_read_addr (o,32), mem_read_data (i,32), mem_read_val (i,1): refill beat channel.

Function
REQ-017 Each way entry SHALL hold valid, dirty, TAG and LINE_WORDS data words; each set SHALL hold a victim pointer of log2(WAYS) bits (0 bits when WAYS = 1).
REQ-018 hit SHALL equal datareq AND (some way in the indexed set is valid with a matching tag); at most one way SHALL match.
REQ-019 FSM states SHALL be IDLE, WRBACK and REFILL; reset state SHALL be IDLE.
REQ-020 IDLE, hit load: readdata SHALL take the addressed word on the next edge.
REQ-021 IDLE, otherwise: readdata SHALL be 0 on the next edge.
REQ-022 IDLE, hit store: the enabled bytes of the addressed word SHALL be written on the same edge and the way's dirty bit set; no stall.
REQ-023 IDLE, miss, victim valid and dirty: FSM SHALL go to WRBACK and latch the victim tag, index, victim way and request address.
REQ-024 IDLE, miss, victim not dirty: FSM SHALL go to REFILL and latch the same items.
REQ-025 Victim selection SHALL be the lowest-numbered invalid way if one exists, else the way given by the set's victim pointer.
REQ-026 stall SHALL be 1 while datareq is 1 and (FSM is not IDLE or hit is 0); otherwise 0.
REQ-027 WRBACK: mem_write_req SHALL be 1.
REQ-028 WRBACK: mem_write_addr SHALL be {victim tag, index, OFF zero bits}.
REQ-029 WRBACK: mem_write_data SHALL combinationally present victim word[wcnt].
REQ-030 WRBACK: each mem_write_val SHALL increment wcnt; on the LINE_WORDS-th beat wcnt SHALL clear and FSM SHALL go to REFILL.
REQ-031 REFILL: mem_read_req SHALL be 1 and mem_read_addr SHALL be the latched address with its low OFF bits zeroed.
REQ-032 REFILL: each mem_read_val SHALL store mem_read_data into line word[rcnt] and increment rcnt.
REQ-033 REFILL, last beat: the victim way SHALL be written valid=1, dirty=0 with the new tag, rcnt SHALL clear, and FSM SHALL go to IDLE.
REQ-034 REFILL, last beat: the set's victim pointer SHALL advance by 1 modulo WAYS.
REQ-035 A miss SHALL be serviced by replay: the held request SHALL hit in the cycle after return to IDLE and complete per REQ-020/022.
REQ-036 Val inputs SHALL be ignored when the corresponding req is 0; a beat with val=0 SHALL not advance any counter.
REQ-037 Changes on datareq, dataaddr, wren, byteen or writedata while not IDLE SHALL NOT affect the fill in progress.

Reset
REQ-038 Asserting reset SHALL immediately clear all valid and dirty bits, victim pointers, wcnt, rcnt and readdata, and set FSM to IDLE.
REQ-039 During reset, mem_write_req, mem_read_req and stall SHALL be 0 and mem_write_data SHALL be 0.
REQ-040 Reset asserted mid-WRBACK or mid-REFILL SHALL abort the burst with no partial line installed.

Verification
REQ-041 Defaults, cold load of 0x100, memory returns 0x10..0x17 -> stall for exactly 8 read beats, mem_read_addr 0x100, no write request; replay readdata 0x10.
REQ-042 Store 0xAABBCCDD with byteen=0101 to 0x104, a hit on old 0x11 -> word becomes 0x00BB00DD, dirty=1, no stall.
REQ-043 Loads to 0x100, then 0x200, then 0x300, same set, with the 0x100 line dirty -> the 0x300 miss evicts way 0.
REQ-044 Continuing REQ-043 -> 8 write beats at 0x100 carrying line words 0..7 in order, followed by a refill from 0x300.
REQ-045 Inject mem_read_val gaps of 0-3 cycles during refill -> exactly 8 words captured in order, rcnt returns to 0.
REQ-046 Assert reset on the 4th refill beat -> requests drop the same cycle; a later load to the same address misses again.
